sigmoid_pipe: RTL and testbench



---
 rtl/sigmoid_pipe.sv | 111 +++++++++++
 tb/tb_sigmoid_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_pipe.sv
// Three-stage pipelined sigmoid: decode, 65-entry ROM read, linear interpolation with symmetric fold.
// A single global stall (adv) freezes every stage when the output is held by the consumer.
module sigmoid_pipe #(
  parameter int IN_W   = 22,
  parameter int FRAC_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   suma,
  input  logic              predznak,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       vjerojatnost
);

  localparam int FW = FRAC_W - 3;

  // round(65536 / (1 + exp(-i/8))), i = 0..64
  localparam logic [15:0] LUT [0:64] = '{
    16'd32768, 16'd34813, 16'd36843, 16'd38841, 16'd40793, 16'd42687, 16'd44511, 16'd46254,
    16'd47911, 16'd49474, 16'd50941, 16'd52310, 16'd53581, 16'd54754, 16'd55834, 16'd56822,
    16'd57724, 16'd58544, 16'd59287, 16'd59959, 16'd60565, 16'd61109, 16'd61598, 16'd62036,
    16'd62428, 16'd62778, 16'd63090, 16'd63368, 16'd63615, 16'd63835, 16'd64030, 16'd64203,
    16'd64357, 16'd64494, 16'd64614, 16'd64721, 16'd64816, 16'd64900, 16'd64974, 16'd65039,
    16'd65097, 16'd65149, 16'd65194, 16'd65234, 16'd65269, 16'd65300, 16'd65328, 16'd65352,
    16'd65374, 16'd65393, 16'd65410, 16'd65425, 16'd65438, 16'd65449, 16'd65459, 16'd65468,
    16'd65476, 16'd65483, 16'd65489, 16'd65495, 16'd65500, 16'd65504, 16'd65508, 16'd65511,
    16'd65514
  };

  logic adv;
  logic v1, v2, v3;

  logic          s1_sat;
  logic [5:0]    s1_idx;
  logic [FW-1:0] s1_f;
  logic          s1_neg;

  logic [15:0]   s2_a;
  logic [15:0]   s2_b;
  logic [FW-1:0] s2_f;
  logic          s2_neg;

  assign adv       = ~v3 | out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;

  // Stage 1 decode: bits above the LUT range only flag saturation.
  logic          d_sat;
  logic [5:0]    d_idx;
  logic [FW-1:0] d_f;

  assign d_sat = |suma[IN_W-1:FRAC_W+3];
  assign d_idx = suma[FRAC_W+2:FRAC_W-3];
  assign d_f   = suma[FRAC_W-4:0];

  // Stage 2 ROM read; idx tops out at 63, so idx+1 never leaves the table.
  logic [6:0]    lo_idx;
  logic [6:0]    hi_idx;
  logic [15:0]   rom_a;
  logic [15:0]   rom_b;
  logic [FW-1:0] rom_f;

  assign lo_idx = {1'b0, s1_idx};
  assign hi_idx = lo_idx + 7'd1;
  assign rom_a  = s1_sat ? LUT[64] : LUT[lo_idx];
  assign rom_b  = LUT[hi_idx];
  assign rom_f  = s1_sat ? '0 : s1_f;

  // Stage 3: p = a + floor((b-a)*f / 2^FW) stays within [a, b], so 16 bits suffice.
  // Folding 65536 - p modulo 2^16 is the two's complement of p; p is never 0.
  logic [15:0] diff;
  logic [15:0] p;
  logic [15:0] folded;

  assign diff   = s2_b - s2_a;
  assign p      = s2_a + 16'(({{FW{1'b0}}, diff} * {16'd0, s2_f}) >> FW);
  assign folded = s2_neg ? (~p + 16'd1) : p;

  // NOTE: non-blocking assignments let each stage capture its predecessor's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1           <= 1'b0;
      v2           <= 1'b0;
      v3           <= 1'b0;
      vjerojatnost <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      if (v2) vjerojatnost <= folded;
    end
  end

  // NOTE: payload registers have no reset; the valid bits alone say whether they hold a sample.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sat <= d_sat;
      s1_idx <= d_idx;
      s1_f   <= d_f;
      s1_neg <= predznak;
      s2_a   <= rom_a;
      s2_b   <= rom_b;
      s2_f   <= rom_f;
      s2_neg <= s1_neg;
    end
  end

endmodule

// File: tb/tb_sigmoid_pipe.sv
// Directed bench for sigmoid_pipe: reset state, latency, LUT/interpolation/saturation points,
// backpressure ordering and hold, and mid-flight reset flush.
module tb_sigmoid_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] suma;
  logic        predznak;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] vjerojatnost;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sigmoid_pipe #(.IN_W(22), .FRAC_W(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .suma         (suma),
    .predznak     (predznak),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .vjerojatnost (vjerojatnost)
  );

  typedef struct {
    logic [21:0] s;
    logic        n;
    logic [15:0] e;
  } vec_t;

  vec_t        singles[$];
  vec_t        stream[$];
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [21:0] s, input logic n, input logic [15:0] e);
    vec_t v;
    v.s = s;
    v.n = n;
    v.e = e;
    return v;
  endfunction

  // One isolated sample on an idle pipe with out_ready = 1.
  task automatic single(input string tag, input vec_t v);
    int lat;
    in_valid = 1'b1;
    suma     = v.s;
    predznak = v.n;
    step();
    lat      = 1;
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_value"}, 32'(vjerojatnost), 32'(v.e));
    step();
  endtask

  initial begin
    int   sent;
    int   got;
    int   extra;
    logic held;
    logic [15:0] held_val;
    logic [5:0]  pat;
    logic [15:0] e;

    rst       = 1'b1;
    in_valid  = 1'b0;
    suma      = '0;
    predznak  = 1'b0;
    out_ready = 1'b1;

    singles.push_back(mk(22'h000000, 1'b0, 16'd32768));
    singles.push_back(mk(22'h000000, 1'b1, 16'd32768));
    singles.push_back(mk(22'h000400, 1'b0, 16'd47911));
    singles.push_back(mk(22'h000400, 1'b1, 16'd17625));
    singles.push_back(mk(22'h000040, 1'b0, 16'd33790));
    singles.push_back(mk(22'h000040, 1'b1, 16'd31746));
    singles.push_back(mk(22'h000080, 1'b0, 16'd34813));
    singles.push_back(mk(22'h00007F, 1'b0, 16'd34797));
    singles.push_back(mk(22'h3FFFFF, 1'b0, 16'd65514));
    singles.push_back(mk(22'h3FFFFF, 1'b1, 16'd22));
    singles.push_back(mk(22'h002000, 1'b0, 16'd65514));
    singles.push_back(mk(22'h002345, 1'b1, 16'd22));
    singles.push_back(mk(22'h001FFF, 1'b0, 16'd65513));

    stream.push_back(mk(22'h000400, 1'b0, 16'd47911));
    stream.push_back(mk(22'h000040, 1'b0, 16'd33790));
    stream.push_back(mk(22'h3FFFFF, 1'b1, 16'd22));
    stream.push_back(mk(22'h000080, 1'b1, 16'd30723));
    stream.push_back(mk(22'h00007F, 1'b0, 16'd34797));
    stream.push_back(mk(22'h000400, 1'b1, 16'd17625));

    step();
    step();
    rst = 1'b0;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_vjerojatnost", 32'(vjerojatnost), 32'd0);

    foreach (singles[i]) single($sformatf("single%0d", i), singles[i]);

    // Back-to-back stream against a 1,0,0,1,0,1 out_ready pattern.
    pat      = 6'b101001;
    sent     = 0;
    got      = 0;
    held     = 1'b0;
    held_val = '0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      out_ready = pat[c % 6];
      if (sent < 6) begin
        in_valid = 1'b1;
        suma     = stream[sent].s;
        predznak = stream[sent].n;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (held) begin
        check($sformatf("bp_hold_valid_c%0d", c), 32'(out_valid), 32'd1);
        check($sformatf("bp_hold_value_c%0d", c), 32'(vjerojatnost), 32'(held_val));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("bp_out%0d", got), 32'(vjerojatnost), 32'(e));
        end else begin
          check($sformatf("bp_unexpected_out%0d", got), 32'd1, 32'd0);
        end
        got++;
      end
      held     = out_valid && !out_ready;
      held_val = vjerojatnost;
      if (in_valid && in_ready) begin
        exp_q.push_back(stream[sent].e);
        sent++;
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_outputs_received", 32'(got), 32'd6);

    extra = 0;
    repeat (6) begin
      if (out_valid) extra++;
      step();
    end
    check("bp_no_duplicates", 32'(extra), 32'd0);

    // Fill three stages with out_ready low, then reset mid-flight.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      suma     = stream[k].s;
      predznak = stream[k].n;
      step();
    end
    in_valid = 1'b0;
    check("flush_pipe_full", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_vjerojatnost", 32'(vjerojatnost), 32'd0);
    out_ready = 1'b1;
    extra = 0;
    repeat (8) begin
      if (out_valid) extra++;
      step();
    end
    check("flush_no_leak", 32'(extra), 32'd0);

    single("after_flush", mk(22'h000400, 1'b1, 16'd17625));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
